// File: rtl/if_id_skid_pkg.sv
// Shared encodings and default widths for the IF->ID pipeline boundary.
package if_id_skid_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam int          INST_BUS_W  = 32;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] NOP_ENC     = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_if.sv
// Valid/ready word channel carrying {pc, inst} between pipeline stages.
interface if_id_skid_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/if_id_skid_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by the per-stage perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/if_id_skid.sv
// IF->ID boundary: 2-entry skid buffer on a valid/ready channel with flush and a stall-cycle counter.
//   state | meaning
//   EMPTY | no word held, bubble on dn
//   ONE   | main slot holds the word presented to decode
//   TWO   | main and skid both hold words, upstream blocked
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_ENC),
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  if_id_skid_if.slave      up,
  if_id_skid_if.master     dn,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_e       state_q, state_d;
  logic              main_valid_q, skid_valid_q;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic              up_fire, dn_fire;

  // up.ready is a pure flop output so decode backpressure never reaches fetch combinationally.
  assign up.ready = ~skid_valid_q;
  assign up_fire  = up.valid & ~skid_valid_q;
  assign dn_fire  = main_valid_q & dn.ready & ~stall;

  assign dn.valid = main_valid_q;
  assign dn.pc    = main_valid_q ? main_pc_q   : ADDR_W'(ZERO_WORD);
  assign dn.inst  = main_valid_q ? main_inst_q : NOP_INST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pc_q    <= '0;
      skid_pc_q    <= '0;
      main_inst_q  <= NOP_INST;
      skid_inst_q  <= NOP_INST;
    end else begin
      state_q      <= state_d;
      main_valid_q <= (state_d != EMPTY);
      skid_valid_q <= (state_d == TWO);
      main_pc_q    <= main_pc_d;
      skid_pc_q    <= skid_pc_d;
      main_inst_q  <= main_inst_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (up_fire) begin
          main_pc_d   = up.pc;
          main_inst_d = up.inst;
          state_d     = ONE;
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            main_pc_d   = up.pc;
            main_inst_d = up.inst;
          end else if (up_fire) begin
            skid_pc_d   = up.pc;
            skid_inst_d = up.inst;
            state_d     = TWO;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: if (dn_fire) begin
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
          state_d     = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (main_valid_q & ~dn_fire),
    .cnt (stall_cnt)
  );

  a_no_fire_in_two: assert property (@(posedge clk) disable iff (rst)
    !((state_q == TWO) && up_fire));

endmodule

// File: tb/tb_if_id_skid.sv
// Randomized scoreboard bench for if_id_skid: a FIFO reference model predicts every output cycle.
module tb_if_id_skid;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, stall = 1'b0;
  logic        upv = 1'b0, dnr = 1'b0;
  logic [31:0] upc = '0, uinst = '0;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  word_t       sb_q[$];
  int unsigned exp_cnt = 0;
  bit          chk_en = 0, ready_snap = 1, cnt_inc = 0;
  int          n_cmp = 0, n_err = 0;

  if_id_skid_if up_a (), dn_a (), up_b (), dn_b ();

  assign up_a.valid = upv;  assign up_a.pc = upc;  assign up_a.inst = uinst;
  assign up_b.valid = upv;  assign up_b.pc = upc;  assign up_b.inst = uinst;
  assign dn_a.ready = dnr;
  assign dn_b.ready = dnr;

  if_id_skid #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .up(up_a), .dn(dn_a), .stall_cnt(cnt_a)
  );
  if_id_skid #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .up(up_b), .dn(dn_b), .stall_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: compares what decode sees against the model, then retires the word decode takes.
  always @(negedge clk) begin
    if (chk_en) begin
      bit    ev, dfire;
      word_t hd;
      ev = (sb_q.size() > 0);
      hd = ev ? sb_q[0] : '{32'h0, 32'h0};
      chk("dn_valid",  {63'd0, dn_a.valid}, {63'd0, ev});
      chk("dn_pc",     {32'd0, dn_a.pc},    {32'd0, hd.pc});
      chk("dn_inst",   {32'd0, dn_a.inst},  {32'd0, hd.inst});
      chk("up_ready",  {63'd0, up_a.ready}, {63'd0, (sb_q.size() < 2)});
      chk("stall_cnt", {48'd0, cnt_a},      sat(exp_cnt, 65535));
      chk("stall_cnt_w4", {60'd0, cnt_b},   sat(exp_cnt, 15));
      ready_snap = (sb_q.size() < 2);
      dfire      = ev && dnr && !stall;
      cnt_inc    = ev && !dfire;
      if (dfire && !flush && !rst) void'(sb_q.pop_front());
    end
  end

  // One clock of stimulus; the model absorbs accepted words at the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic dr, input logic st,
                     input logic fl);
    rst = r; upv = v; upc = pc; uinst = inst; dnr = dr; stall = st; flush = fl;
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      exp_cnt = 0;
    end else begin
      if (cnt_inc) exp_cnt++;
      if (fl) sb_q.delete();
      else if (v && ready_snap) sb_q.push_back('{pc, inst});
    end
    chk_en = 1;
    #1;
  endtask

  initial begin
    logic [31:0] pc_r;
    // reset with a word already offered
    cyc(1, 1, 32'h0, 32'h2408_0005, 1, 0, 0);
    cyc(1, 1, 32'h0, 32'h2408_0005, 1, 0, 0);
    // streaming
    cyc(0, 1, 32'h00, 32'hA, 1, 0, 0);
    cyc(0, 1, 32'h04, 32'hB, 1, 0, 0);
    cyc(0, 1, 32'h08, 32'hC, 1, 0, 0);
    repeat (2) cyc(0, 0, 32'h0, 32'h0, 1, 0, 0);
    // backpressure: 0x18 stays offered until taken
    cyc(0, 1, 32'h10, 32'h1010, 0, 0, 0);
    cyc(0, 1, 32'h14, 32'h1014, 0, 0, 0);
    repeat (2) cyc(0, 1, 32'h18, 32'h1018, 0, 0, 0);
    repeat (2) cyc(0, 1, 32'h18, 32'h1018, 1, 0, 0);
    repeat (3) cyc(0, 0, 32'h0, 32'h0, 1, 0, 0);
    // stall wins over dn_ready
    cyc(0, 1, 32'h30, 32'h1030, 1, 0, 0);
    repeat (3) cyc(0, 1, 32'h34, 32'h1034, 1, 1, 0);
    cyc(0, 1, 32'h38, 32'h1038, 1, 0, 0);
    repeat (4) cyc(0, 0, 32'h0, 32'h0, 1, 0, 0);
    // flush while full, with 0x40 on offer
    cyc(0, 1, 32'h20, 32'h1020, 0, 0, 0);
    cyc(0, 1, 32'h24, 32'h1024, 0, 0, 0);
    cyc(0, 1, 32'h40, 32'h1040, 0, 0, 1);
    repeat (2) cyc(0, 0, 32'h0, 32'h0, 1, 0, 0);
    // long hold to saturate the narrow counter
    cyc(0, 1, 32'h50, 32'h1050, 0, 0, 0);
    repeat (20) cyc(0, 0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) cyc(0, 0, 32'h0, 32'h0, 1, 0, 0);
    // random traffic with occasional flush and reset
    pc_r = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      logic v, dr, st, fl, r;
      v  = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 31) == 0);
      r  = ($urandom_range(0, 499) == 0);
      cyc(r, v, pc_r, $urandom, dr, st, fl);
      if (v && !upv) pc_r = pc_r;
      if (v) pc_r = pc_r + 32'd4;
    end
    repeat (4) cyc(0, 0, 32'h0, 32'h0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
